fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the 32x8 synchronous FIFO between `NUM_REQ` independent producers. Each producer offers words with a valid/ready handshake. The arbiter grants one producer per cycle, drives the FIFO `we`/`data_in` pins combinationally, and applies FIFO `full` as backpressure. A burst lock keeps a producer granted for up to `MAX_BURST` consecutive words, so short packets stay contiguous in the FIFO.

## Interface
- `NUM_REQ`, 4: number of producers; must be ≥ 2.
- `DATA_WIDTH`, 32: word width; matches FIFO `data_in`.
- `MAX_BURST`, 4: maximum consecutive transfers per ownership; must be ≥ 1.
- `clk`  in  1: clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset).
- `req_valid`  in  NUM_REQ: producer i has a word on its data slice.
- `req_data`  in  NUM_REQ*DATA_WIDTH: producer i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ: one-hot or zero; word i is accepted this cycle.
- `fifo_full`  in  1: FIFO full flag.
- `fifo_we`  out  1: FIFO write enable.
- `fifo_data`  out  DATA_WIDTH: FIFO write data.
- `grant_id`  out  clog2(NUM_REQ): index of the currently selected producer (valid when `fifo_we`=1).
- `busy`  out  1: burst lock held (state OWN).

## Operation
- State: `state` ∈ {IDLE, OWN}, `owner` (clog2(NUM_REQ)), `burst_cnt` (clog2(MAX_BURST+1)), `rr_ptr` (clog2(NUM_REQ)).
- Selection, combinational, each cycle:
  - If state = OWN and `req_valid[owner]`=1, select `owner`.
  - Otherwise select the first i with `req_valid[i]`=1, scanning `rr_ptr`, `rr_ptr+1`, … modulo NUM_REQ.
  - If no producer is valid, there is no selection.
- `fifo_we` = a selection exists. `fifo_data` = `req_data` slice of the selected producer. `grant_id` = selected index.
- `req_ready[sel]` = `fifo_we` & ~`fifo_full`. A transfer of producer k occurs when `req_valid[k]` & `req_ready[k]`.
- On a transfer by producer k:
  - If state = IDLE or k ≠ `owner`: new burst. Set `owner`=k, `burst_cnt`=1, `rr_ptr`=(k+1) mod NUM_REQ. Next state is OWN, or IDLE if MAX_BURST=1.
  - Otherwise (k = `owner`): `burst_cnt`+1. If this equals MAX_BURST, next state is IDLE and `burst_cnt`=0.
- No transfer, state OWN, and `req_valid[owner]`=0: next state IDLE (owner abandoned burst).
- No transfer otherwise (including `fifo_full`=1 with the owner valid): all state holds and `burst_cnt` is frozen.
- `rr_ptr` wraps from NUM_REQ-1 to 0.

## Timing
- Zero-cycle combinational paths: `req_valid`/`req_data` → `fifo_we`/`fifo_data`, and `fifo_full` → `req_ready`. No registered datapath stage; the FIFO samples on the same edge on which the arbiter updates.
- While `reset`=0: state=IDLE, `owner`=0, `burst_cnt`=0, `rr_ptr`=0. All outputs are forced to 0 (`req_ready`, `fifo_we`, `fifo_data`, `grant_id`, `busy`), regardless of inputs.
- Reset mid-burst drops ownership immediately. After release, arbitration restarts from producer 0.
- Producers must hold `req_valid` and data stable until ready. Deasserting valid without a transfer is legal and releases a lock.
- `fifo_full`=1 holds grant and state. The first word after full clears goes to the same producer.
- Maximum wait for a continuously valid producer: (NUM_REQ-1)*MAX_BURST transfers.

## Structure
- Package `fifo_arb_pkg`: state enum (IDLE, OWN) and width helpers for `owner`, `rr_ptr` and `burst_cnt` derived from NUM_REQ and MAX_BURST.
- Sub-module `fifo_rr_pick`: parameterized rotating priority picker.
  - Inputs: request vector, start pointer.
  - Outputs: found flag, index.
  - Purely combinational; instantiated once.
- Top level contains the state registers, the burst counter and the output mux.

## Test plan
- Single producer, full clear: `req_valid`=4'b0001 for 6 words → 6 consecutive writes, `grant_id`=0. `busy` drops after word 4; word 5 starts a new burst.
- All four valid continuously, MAX_BURST=4 → grant sequence 0×4, 1×4, 2×4, 3×4, 0×4; FIFO order matches.
- Backpressure: owner 2 mid-burst (`burst_cnt`=2), `fifo_full`=1 for 3 cycles → `req_ready`=0, no state change. After full clears, producer 2 transfers 2 more words, then releases.
- Abandon: owner 1 drops valid after 1 word while producer 3 is valid → producer 3 is granted in the same cycle. `rr_ptr`=0 after producer 3's first transfer.
- Wrap: `rr_ptr`=3, producers 0 and 3 valid → producer 3 is served first, then producer 0.
- Async reset asserted mid-burst (owner 2, `burst_cnt`=3) → outputs 0 within the same cycle. After release with all producers valid, producer 0 is granted first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Width of a producer index (owner, rr_ptr, grant_id).
    function automatic int idx_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Width of the burst counter, which must hold 0..MAX_BURST.
    function automatic int cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr_i, modulo N.
module fifo_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        int j;
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr_i) + i;
            if (j >= N) j = j - N;
            if (req_i[j]) begin
                found_o = 1'b1;
                idx_o   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO write port between producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_we,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = cnt_w(MAX_BURST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          owner_live;
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic          xfer;

    fifo_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Holding reset low masks every output, whatever the producers drive.
    assign owner_live = (state_q == OWN) && req_valid[owner_q];
    assign sel_found  = reset && (owner_live || pick_found);
    assign sel_idx    = owner_live ? owner_q : pick_idx;
    assign xfer       = sel_found && !fifo_full;

    always_comb begin
        fifo_we   = sel_found;
        fifo_data = sel_found ? req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
        grant_id  = sel_found ? sel_idx : '0;
        busy      = reset && (state_q == OWN);
        req_ready = '0;
        if (xfer) req_ready[sel_idx] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            if (state_q == IDLE || sel_idx != owner_q) begin
                owner_d     = sel_idx;
                burst_cnt_d = CNT_ONE;
                rr_ptr_d    = (sel_idx == IDX_LAST) ? '0 : sel_idx + IDX_ONE;
                state_d     = (MAX_BURST == 1) ? IDLE : OWN;
            end else if (burst_cnt_q + CNT_ONE == CNT_MAX) begin
                burst_cnt_d = '0;
                state_d     = IDLE;
            end else begin
                burst_cnt_d = burst_cnt_q + CNT_ONE;
            end
        end else if (state_q == OWN && !req_valid[owner_q]) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

endmodule
